// File: rtl/ign_sequencer.sv
// Per-channel ignition coil sequencer: dwell/fire pulses to coil drive with overdwell
// timeout, post-spark hold-off and a cap on concurrently dwelling coils. Optional
// IGN_SPARK_COUNT_EN adds the wrapping spark_count output.
module ign_sequencer #(
  parameter int unsigned N_CH      = 8,
  parameter int unsigned CNT_W     = 15,
  parameter int unsigned MAX_DWELL = 16000,
  parameter int unsigned MIN_OFF   = 200,
  parameter int unsigned MAX_CONC  = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            synced,
  input  logic [N_CH-1:0] dwell_req,
  input  logic [N_CH-1:0] fire_req,
  input  logic            clr_faults,
  output logic [N_CH-1:0] ign,
  output logic [N_CH-1:0] reject,
  output logic [N_CH-1:0] overdwell,
  output logic [3:0]      active_cnt
`ifdef IGN_SPARK_COUNT_EN
  ,
  output logic [15:0]     spark_count
`endif
);

  typedef enum logic [1:0] {IDLE, DWELL, HOLDOFF} ch_state_t;

  ch_state_t        state [N_CH];
  logic [CNT_W-1:0] cnt   [N_CH];

  logic [N_CH-1:0] leaving;
  logic [N_CH-1:0] timeout;
  logic [N_CH-1:0] od_set;
  logic [N_CH-1:0] grant;
  int unsigned     running;
  int unsigned     n_leave;

  // Channels leaving DWELL free their slot in the same cycle, so the
  // arbitration base counts only channels that remain dwelling.
  always_comb begin
    leaving = '0;
    timeout = '0;
    od_set  = '0;
    grant   = '0;
    running = 0;
    n_leave = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (state[i] == DWELL) begin
        timeout[i] = (cnt[i] == CNT_W'(MAX_DWELL - 1));
        leaving[i] = !synced || fire_req[i] || timeout[i];
        od_set[i]  = timeout[i] && !fire_req[i] && synced;
        if (leaving[i]) n_leave = n_leave + 1;
        else            running = running + 1;
      end
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (synced && dwell_req[i] && state[i] == IDLE && running < MAX_CONC) begin
        grant[i] = 1'b1;
        running  = running + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      ign         <= '0;
      reject      <= '0;
      overdwell   <= '0;
      active_cnt  <= '0;
`ifdef IGN_SPARK_COUNT_EN
      spark_count <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        case (state[i])
          IDLE: begin
            if (grant[i]) begin
              state[i] <= DWELL;
              cnt[i]   <= '0;
            end
          end
          DWELL: begin
            if (leaving[i]) begin
              state[i] <= HOLDOFF;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          HOLDOFF: begin
            if (cnt[i] == CNT_W'(MIN_OFF - 1)) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
        ign[i]    <= ((state[i] == DWELL) && !leaving[i]) || grant[i];
        reject[i] <= dwell_req[i] && !grant[i];
        if (od_set[i])       overdwell[i] <= 1'b1;
        else if (clr_faults) overdwell[i] <= 1'b0;
      end
      active_cnt <= 4'(running);
`ifdef IGN_SPARK_COUNT_EN
      spark_count <= spark_count + 16'(n_leave);
`endif
    end
  end

endmodule

// File: tb/tb_ign_sequencer.sv
// Directed self-checking bench for ign_sequencer (default parameters; spark_count
// checks enabled when IGN_SPARK_COUNT_EN is defined).
module tb_ign_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       synced;
  logic [7:0] dwell_req;
  logic [7:0] fire_req;
  logic       clr_faults;
  logic [7:0] ign;
  logic [7:0] reject;
  logic [7:0] overdwell;
  logic [3:0] active_cnt;
`ifdef IGN_SPARK_COUNT_EN
  logic [15:0] spark_count;
`endif

  int checks = 0;
  int errors = 0;

  ign_sequencer #(
    .N_CH(8), .CNT_W(15), .MAX_DWELL(16000), .MIN_OFF(200), .MAX_CONC(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .synced     (synced),
    .dwell_req  (dwell_req),
    .fire_req   (fire_req),
    .clr_faults (clr_faults),
    .ign        (ign),
    .reject     (reject),
    .overdwell  (overdwell),
    .active_cnt (active_cnt)
`ifdef IGN_SPARK_COUNT_EN
    ,
    .spark_count(spark_count)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; synced = 1'b1; dwell_req = '0; fire_req = '0; clr_faults = 1'b0;
    tick(3);
    checks++;
    if ({ign, reject, overdwell, active_cnt} !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs ign=%h reject=%h od=%h act=%0d expected all 0", ign, reject, overdwell, active_cnt);
    end
`ifdef IGN_SPARK_COUNT_EN
    checks++;
    if (spark_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_spark got %0d expected 0", spark_count);
    end
`endif
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_fire;
    dwell_req = 8'h01;
    for (int k = 1; k <= 100; k++) begin
      tick(1);
      dwell_req = '0;
      checks++;
      if (ign[0] !== 1'b1 || reject !== 8'h00) begin
        errors++;
        $display("FAIL basic_dwell k=%0d ign=%h reject=%h expected ign[0]=1 reject=00", k, ign, reject);
      end
      if (k == 100) fire_req = 8'h01;
    end
    tick(1);
    fire_req = '0;
    checks++;
    if (ign !== 8'h00 || reject !== 8'h00 || overdwell !== 8'h00 || active_cnt !== 4'd0) begin
      errors++;
      $display("FAIL basic_fire ign=%h reject=%h od=%h act=%0d expected 00/00/00/0", ign, reject, overdwell, active_cnt);
    end
    tick(250);
  endtask

  task automatic test_overdwell;
    int hi_cnt;
    int od_at;
    hi_cnt = 0;
    od_at  = 0;
    dwell_req = 8'h08;
    for (int k = 1; k <= 16100; k++) begin
      tick(1);
      dwell_req = '0;
      if (ign[3]) hi_cnt++;
      if (overdwell[3] && od_at == 0) od_at = k;
    end
    checks++;
    if (hi_cnt != 16000) begin
      errors++;
      $display("FAIL overdwell_len got %0d expected 16000", hi_cnt);
    end
    checks++;
    if (od_at != 16001) begin
      errors++;
      $display("FAIL overdwell_set_cycle got %0d expected 16001", od_at);
    end
    tick(50);
    checks++;
    if (overdwell !== 8'h08) begin
      errors++;
      $display("FAIL overdwell_sticky got %h expected 08", overdwell);
    end
    clr_faults = 1'b1;
    tick(1);
    clr_faults = 1'b0;
    checks++;
    if (overdwell !== 8'h00) begin
      errors++;
      $display("FAIL overdwell_clear got %h expected 00", overdwell);
    end
    tick(250);
  endtask

  task automatic test_conc_cap;
    dwell_req = 8'h07;
    tick(1);
    dwell_req = '0;
    checks++;
    if (ign !== 8'h03 || reject !== 8'h04 || active_cnt !== 4'd2) begin
      errors++;
      $display("FAIL cap_grant ign=%h reject=%h act=%0d expected 03/04/2", ign, reject, active_cnt);
    end
    tick(1);
    checks++;
    if (reject !== 8'h00) begin
      errors++;
      $display("FAIL cap_reject_pulse got %h expected 00", reject);
    end
    // Slot freed by a fire is reusable in the same cycle.
    fire_req = 8'h01; dwell_req = 8'h04;
    tick(1);
    fire_req = '0; dwell_req = '0;
    checks++;
    if (ign !== 8'h06 || reject !== 8'h00 || active_cnt !== 4'd2) begin
      errors++;
      $display("FAIL cap_handover ign=%h reject=%h act=%0d expected 06/00/2", ign, reject, active_cnt);
    end
    fire_req = 8'h06;
    tick(1);
    fire_req = '0;
    checks++;
    if (ign !== 8'h00 || active_cnt !== 4'd0) begin
      errors++;
      $display("FAIL cap_release ign=%h act=%0d expected 00/0", ign, active_cnt);
    end
    tick(250);
  endtask

  task automatic test_holdoff;
    dwell_req = 8'h01;
    tick(1);
    dwell_req = '0;
    tick(9);
    fire_req = 8'h01;          // fire cycle F
    tick(1);                   // ign falls at F+1
    fire_req = '0;
    tick(149);
    dwell_req = 8'h01;         // F+150
    tick(1);
    dwell_req = '0;
    checks++;
    if (reject !== 8'h01 || ign !== 8'h00) begin
      errors++;
      $display("FAIL holdoff_early reject=%h ign=%h expected 01/00", reject, ign);
    end
    tick(49);
    dwell_req = 8'h01;         // F+200, last hold-off cycle
    tick(1);
    checks++;
    if (reject !== 8'h01 || ign !== 8'h00) begin
      errors++;
      $display("FAIL holdoff_edge reject=%h ign=%h expected 01/00", reject, ign);
    end
    tick(1);                   // dwell_req still high: sampled at F+201
    dwell_req = '0;
    checks++;
    if (reject !== 8'h00 || ign !== 8'h01) begin
      errors++;
      $display("FAIL holdoff_retry reject=%h ign=%h expected 00/01", reject, ign);
    end
    fire_req = 8'h01;
    tick(1);
    fire_req = '0;
    tick(250);
  endtask

  task automatic test_sync_loss;
    dwell_req = 8'h06;
    tick(1);
    dwell_req = '0;
    checks++;
    if (ign !== 8'h06) begin
      errors++;
      $display("FAIL sync_setup ign=%h expected 06", ign);
    end
    tick(5);
    synced = 1'b0; dwell_req = 8'h01;
    tick(1);
    dwell_req = 8'h20;
    checks++;
    if (ign !== 8'h00 || reject !== 8'h01 || overdwell !== 8'h00 || active_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sync_abort ign=%h reject=%h od=%h act=%0d expected 00/01/00/0", ign, reject, overdwell, active_cnt);
    end
    tick(1);
    dwell_req = '0;
    checks++;
    if (reject !== 8'h20 || ign !== 8'h00) begin
      errors++;
      $display("FAIL sync_inhibit reject=%h ign=%h expected 20/00", reject, ign);
    end
    synced = 1'b1;
    tick(250);
  endtask

  task automatic test_async_reset;
    dwell_req = 8'h02;
    tick(1);
    dwell_req = '0;
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ign, reject, overdwell, active_cnt} !== 28'h0) begin
      errors++;
      $display("FAIL async_reset ign=%h reject=%h od=%h act=%0d expected all 0", ign, reject, overdwell, active_cnt);
    end
    tick(2);
    reset_n = 1'b1;
    tick(1);
`ifdef IGN_SPARK_COUNT_EN
    dwell_req = 8'h03;
    tick(1);
    dwell_req = '0;
    tick(4);
    fire_req = 8'h03;
    tick(1);
    fire_req = '0;
    dwell_req = 8'h04;
    tick(1);
    dwell_req = '0;
    tick(4);
    fire_req = 8'h04;
    tick(1);
    fire_req = '0;
    tick(1);
    checks++;
    if (spark_count !== 16'd3) begin
      errors++;
      $display("FAIL spark_count got %0d expected 3", spark_count);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_basic_fire;
    test_overdwell;
    test_conc_cap;
    test_holdoff;
    test_sync_loss;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
